// File: rtl/hub75_capture.sv
`default_nettype none
// ============================================================================
// Module      : hub75_capture
// Description : HUB75 receive side. Samples the panel shift clock, latch
//               strobe, row address and RGB lines (all asynchronous to
//               display_clock), rebuilds each shifted line in a double-
//               buffered line store and drains it as one valid/ready beat
//               per column, tagged with row, column and bit-plane.
// Ports       : display_clock / display_reset_n - sole clock, async low reset
//               hub_clk, hub_stb, hub_row, hub_rgb - raw HUB75 inputs
//               cap_valid / cap_ready             - output beat handshake
//               cap_row, cap_col, cap_plane, cap_rgb, cap_frame - beat fields
//               err_overrun, err_length           - sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module hub75_capture #(
    parameter int WIDTH       = 96,
    parameter int COLOR_DEPTH = 6,
    parameter int BITS_WIDTH  = 7,
    parameter int BITS_ROW    = 5,
    parameter int BITS_PLANE  = 3
) (
    input  logic                  display_clock,
    input  logic                  display_reset_n,
    input  logic                  hub_clk,
    input  logic                  hub_stb,
    input  logic [BITS_ROW-1:0]   hub_row,
    input  logic [5:0]            hub_rgb,
    output logic                  cap_valid,
    input  logic                  cap_ready,
    output logic [BITS_ROW-1:0]   cap_row,
    output logic [BITS_WIDTH-1:0] cap_col,
    output logic [BITS_PLANE-1:0] cap_plane,
    output logic [5:0]            cap_rgb,
    output logic                  cap_frame,
    output logic                  err_overrun,
    output logic                  err_length
);

    // Shift count needs one extra bit so that it can hold WIDTH itself.
    localparam logic [BITS_WIDTH:0]   C_CNT_FULL   = (BITS_WIDTH+1)'(WIDTH);
    localparam logic [BITS_WIDTH-1:0] C_LAST_COL   = BITS_WIDTH'(WIDTH-1);
    localparam logic [BITS_PLANE-1:0] C_LAST_PLANE = BITS_PLANE'(COLOR_DEPTH-1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    // ---------------- input synchronisers ----------------
    // [0],[1] form the two-flop synchroniser, [2] is the previous value.
    logic [2:0]          r_clk_sync;
    logic [2:0]          r_stb_sync;
    logic [BITS_ROW-1:0] r_row_s1, r_row_s2;
    logic [5:0]          r_rgb_s1, r_rgb_s2;

    always_ff @(posedge display_clock or negedge display_reset_n) begin
        if (!display_reset_n) begin
            r_clk_sync <= '0;
            r_stb_sync <= '0;
            r_row_s1   <= '0;
            r_row_s2   <= '0;
            r_rgb_s1   <= '0;
            r_rgb_s2   <= '0;
        end else begin
            r_clk_sync <= {r_clk_sync[1:0], hub_clk};
            r_stb_sync <= {r_stb_sync[1:0], hub_stb};
            r_row_s1   <= hub_row;
            r_row_s2   <= r_row_s1;
            r_rgb_s1   <= hub_rgb;
            r_rgb_s2   <= r_rgb_s1;
        end
    end

    logic w_shift, w_strobe;
    assign w_shift  = r_clk_sync[1] & ~r_clk_sync[2];
    assign w_strobe = r_stb_sync[1] & ~r_stb_sync[2];

    // ---------------- capture side ----------------
    logic [BITS_WIDTH:0]               r_cnt;
    logic                              r_wbank;
    logic                              r_blocked;
    logic [BITS_ROW-1:0]               r_last_row;
    logic [BITS_PLANE-1:0]             r_plane;
    logic [1:0]                        r_full;
    logic [1:0][BITS_ROW-1:0]          r_bank_row;
    logic [1:0][BITS_PLANE-1:0]        r_bank_plane;
    logic                              r_err_overrun, r_err_length;

    logic [5:0]            r_mem [2][WIDTH];
    logic [5:0]            r_rd_data;

    logic                  r_dbank;
    logic [BITS_WIDTH-1:0] r_col;
    state_t                r_state, w_state_next;

    logic [BITS_WIDTH:0]   w_cnt_inc, w_cnt_now;
    logic                  w_wr_en, w_wr_drop;
    logic [BITS_PLANE-1:0] w_plane_next;
    logic                  w_accept, w_release;
    logic [BITS_WIDTH-1:0] w_rd_col;

    assign w_cnt_inc = (r_cnt == C_CNT_FULL) ? r_cnt : r_cnt + 1'b1;
    // A shift in the same cycle as the strobe counts toward that strobe.
    assign w_cnt_now = w_shift ? w_cnt_inc : r_cnt;

    // The write bank is still full only when both banks hold undrained lines;
    // columns must not land on top of them, so the line is flagged as blocked
    // and dropped at its strobe even if the bank frees up mid-line.
    assign w_wr_en   = w_shift && (r_cnt != C_CNT_FULL) && !r_full[r_wbank];
    assign w_wr_drop = w_shift && (r_cnt != C_CNT_FULL) &&  r_full[r_wbank];

    assign w_plane_next = (r_row_s2 != r_last_row)  ? '0 :
                          (r_plane == C_LAST_PLANE) ? '0 : r_plane + 1'b1;

    always_ff @(posedge display_clock or negedge display_reset_n) begin
        if (!display_reset_n) begin
            r_cnt         <= '0;
            r_wbank       <= 1'b0;
            r_blocked     <= 1'b0;
            r_last_row    <= '1;
            r_plane       <= '0;
            r_full        <= '0;
            r_bank_row    <= '0;
            r_bank_plane  <= '0;
            r_err_overrun <= 1'b0;
            r_err_length  <= 1'b0;
        end else begin
            if (w_shift) begin
                r_cnt <= w_cnt_inc;
            end
            if (w_wr_drop) begin
                r_blocked <= 1'b1;
            end
            if (w_release) begin
                r_full[r_dbank] <= 1'b0;
            end
            if (w_strobe) begin
                r_cnt      <= '0;
                r_blocked  <= 1'b0;
                r_plane    <= w_plane_next;
                r_last_row <= r_row_s2;
                if (w_cnt_now != C_CNT_FULL) begin
                    r_err_length <= 1'b1;
                end else if (r_full[r_wbank] || r_blocked || w_wr_drop) begin
                    r_err_overrun <= 1'b1;
                end else begin
                    r_full[r_wbank]       <= 1'b1;
                    r_bank_row[r_wbank]   <= r_row_s2;
                    r_bank_plane[r_wbank] <= w_plane_next;
                    r_wbank               <= ~r_wbank;
                end
            end
        end
    end

    // Line store: no reset so it maps onto distributed or block RAM.
    always_ff @(posedge display_clock) begin
        if (w_wr_en) begin
            r_mem[r_wbank][r_cnt[BITS_WIDTH-1:0]] <= r_rgb_s2;
        end
        r_rd_data <= r_mem[r_dbank][w_rd_col];
    end

    // ---------------- drain side ----------------
    assign w_accept  = (r_state == S_STREAM) && cap_ready;
    assign w_release = w_accept && (r_col == C_LAST_COL);

    // Read one column ahead on acceptance so a new beat is ready every cycle;
    // while stalled the same address is re-read and the beat stays put.
    assign w_rd_col = w_release ? '0 :
                      w_accept  ? r_col + 1'b1 : r_col;

    always_ff @(posedge display_clock or negedge display_reset_n) begin
        if (!display_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (r_full[r_dbank]) w_state_next = S_LOAD;
            S_LOAD:   w_state_next = S_STREAM;
            S_STREAM: if (w_release) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge display_clock or negedge display_reset_n) begin
        if (!display_reset_n) begin
            r_col   <= '0;
            r_dbank <= 1'b0;
        end else if (w_release) begin
            r_col   <= '0;
            r_dbank <= ~r_dbank;
        end else if (w_accept) begin
            r_col   <= r_col + 1'b1;
        end
    end

    // Beat fields are forced to zero outside STREAM, which also keeps the
    // un-reset RAM output from reaching the ports after reset.
    logic w_streaming;
    assign w_streaming = (r_state == S_STREAM);

    assign cap_valid   = w_streaming;
    assign cap_row     = w_streaming ? r_bank_row[r_dbank]   : '0;
    assign cap_plane   = w_streaming ? r_bank_plane[r_dbank] : '0;
    assign cap_col     = w_streaming ? r_col                 : '0;
    assign cap_rgb     = w_streaming ? r_rd_data             : '0;
    assign cap_frame   = w_streaming && (r_bank_row[r_dbank] == '0)
                                     && (r_bank_plane[r_dbank] == '0);
    assign err_overrun = r_err_overrun;
    assign err_length  = r_err_length;

endmodule
`default_nettype wire

// File: tb/tb_hub75_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_hub75_capture
// Description : Self-checking bench for hub75_capture. HUB75 lines are driven
//               at 4 display_clock cycles per column; expected beats are
//               pushed to a scoreboard queue at each strobe and popped by a
//               monitor as the DUT hands them over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hub75_capture;

    localparam int WIDTH = 96;

    logic       display_clock   = 1'b0;
    logic       display_reset_n = 1'b0;
    logic       hub_clk = 1'b0;
    logic       hub_stb = 1'b0;
    logic [4:0] hub_row = '0;
    logic [5:0] hub_rgb = '0;
    logic       cap_ready = 1'b0;
    logic       cap_valid;
    logic [4:0] cap_row;
    logic [6:0] cap_col;
    logic [2:0] cap_plane;
    logic [5:0] cap_rgb;
    logic       cap_frame;
    logic       err_overrun;
    logic       err_length;

    hub75_capture #(
        .WIDTH(WIDTH), .COLOR_DEPTH(6), .BITS_WIDTH(7), .BITS_ROW(5), .BITS_PLANE(3)
    ) dut (
        .display_clock  (display_clock),
        .display_reset_n(display_reset_n),
        .hub_clk        (hub_clk),
        .hub_stb        (hub_stb),
        .hub_row        (hub_row),
        .hub_rgb        (hub_rgb),
        .cap_valid      (cap_valid),
        .cap_ready      (cap_ready),
        .cap_row        (cap_row),
        .cap_col        (cap_col),
        .cap_plane      (cap_plane),
        .cap_rgb        (cap_rgb),
        .cap_frame      (cap_frame),
        .err_overrun    (err_overrun),
        .err_length     (err_length)
    );

    always #5 display_clock = ~display_clock;

    typedef struct packed {
        logic [4:0] row;
        logic [6:0] col;
        logic [2:0] plane;
        logic [5:0] rgb;
        logic       frame;
    } beat_t;

    beat_t sb[$];
    int    n_cmp    = 0;
    int    n_bad    = 0;
    int    n_beats  = 0;
    int    n_frames = 0;

    // Bench-side plane tracking
    logic [4:0] m_last_row = '1;
    logic [2:0] m_plane    = '0;

    // ---------------- monitor ----------------
    beat_t obs, exp_b, held;
    bit    stall_pending = 1'b0;

    always @(negedge display_clock) begin
        obs = {cap_row, cap_col, cap_plane, cap_rgb, cap_frame};
        if (!display_reset_n) begin
            stall_pending = 1'b0;
        end else begin
            if (stall_pending) begin
                n_cmp++;
                if (!cap_valid || obs !== held) begin
                    n_bad++;
                    $display("FAIL stall_hold: got valid=%0b row=%0d col=%0d plane=%0d rgb=%h, want row=%0d col=%0d plane=%0d rgb=%h held",
                             cap_valid, obs.row, obs.col, obs.plane, obs.rgb,
                             held.row, held.col, held.plane, held.rgb);
                end
            end
            if (cap_valid && cap_ready) begin
                n_beats++;
                if (cap_frame) n_frames++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_beat: got row=%0d col=%0d plane=%0d rgb=%h, want no beat",
                             obs.row, obs.col, obs.plane, obs.rgb);
                end else begin
                    exp_b = sb.pop_front();
                    if (obs !== exp_b) begin
                        n_bad++;
                        $display("FAIL beat: got row=%0d col=%0d plane=%0d rgb=%h frame=%0b, want row=%0d col=%0d plane=%0d rgb=%h frame=%0b",
                                 obs.row, obs.col, obs.plane, obs.rgb, obs.frame,
                                 exp_b.row, exp_b.col, exp_b.plane, exp_b.rgb, exp_b.frame);
                    end
                end
            end
            stall_pending = cap_valid && !cap_ready;
            held          = obs;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_ready(input logic v);
        @(posedge display_clock);
        #1 cap_ready = v;
    endtask

    // Shift ncols columns (rgb = col + seed), then strobe row. Expected beats
    // are queued only when the line is expected to be committed.
    task automatic send_line(input logic [4:0] row, input int ncols,
                             input int seed, input bit expect_commit);
        for (int c = 0; c < ncols; c++) begin
            @(negedge display_clock);
            hub_clk = 1'b0;
            hub_rgb = 6'(c + seed);
            repeat (2) @(negedge display_clock);
            hub_clk = 1'b1;
            @(negedge display_clock);
        end
        @(negedge display_clock);
        hub_clk = 1'b0;
        hub_row = row;
        repeat (2) @(negedge display_clock);
        if (row == m_last_row) m_plane = (m_plane == 3'd5) ? 3'd0 : m_plane + 3'd1;
        else                   m_plane = 3'd0;
        m_last_row = row;
        if (expect_commit) begin
            for (int c = 0; c < WIDTH; c++)
                sb.push_back({row, 7'(c), m_plane, 6'(c + seed),
                              (row == 5'd0) && (m_plane == 3'd0)});
        end
        hub_stb = 1'b1;
        repeat (2) @(negedge display_clock);
        hub_stb = 1'b0;
        repeat (2) @(negedge display_clock);
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge display_clock);
            n++;
        end
        ok = (sb.size() == 0);
        repeat (4) @(negedge display_clock);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [24:0] outs;
        repeat (4) @(posedge display_clock);
        #1 outs = {cap_valid, cap_row, cap_col, cap_plane, cap_rgb, cap_frame, err_overrun, err_length};
        n_cmp++;
        if (outs !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs_held: got %h, want 0", outs);
        end
        display_reset_n = 1'b1;
        repeat (4) @(posedge display_clock);
        #1 outs = {cap_valid, cap_row, cap_col, cap_plane, cap_rgb, cap_frame, err_overrun, err_length};
        n_cmp++;
        if (outs !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs_after_release: got %h, want 0", outs);
        end
    endtask

    task automatic test_single_line();
        int b0;
        bit ok;
        set_ready(1'b1);
        b0 = n_beats;
        send_line(5'd3, WIDTH, 0, 1'b1);
        wait_drain(1000, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL single_drain_timeout: got %0d pending, want 0", sb.size()); end
        n_cmp++;
        if (n_beats - b0 != WIDTH) begin n_bad++; $display("FAIL single_beat_count: got %0d, want %0d", n_beats - b0, WIDTH); end
        n_cmp++;
        if ({err_overrun, err_length} !== 2'b00) begin
            n_bad++; $display("FAIL single_errors: got ovr=%0b len=%0b, want 0 0", err_overrun, err_length);
        end
    endtask

    task automatic test_planes();
        int b0, f0;
        bit ok;
        b0 = n_beats;
        f0 = n_frames;
        for (int i = 0; i < 6; i++) send_line(5'd0, WIDTH, 10 * i, 1'b1);
        send_line(5'd1, WIDTH, 7, 1'b1);
        wait_drain(1000, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL planes_drain_timeout: got %0d pending, want 0", sb.size()); end
        n_cmp++;
        if (n_beats - b0 != 7 * WIDTH) begin n_bad++; $display("FAIL planes_beat_count: got %0d, want %0d", n_beats - b0, 7 * WIDTH); end
        n_cmp++;
        if (n_frames - f0 != WIDTH) begin n_bad++; $display("FAIL planes_frame_count: got %0d, want %0d", n_frames - f0, WIDTH); end
    endtask

    task automatic test_length();
        int b0;
        bit ok;
        b0 = n_beats;
        send_line(5'd5, WIDTH - 1, 0, 1'b0);
        repeat (20) @(negedge display_clock);
        n_cmp++;
        if (err_length !== 1'b1) begin n_bad++; $display("FAIL length_flag: got %0b, want 1", err_length); end
        n_cmp++;
        if (n_beats != b0) begin n_bad++; $display("FAIL length_no_beats: got %0d, want 0", n_beats - b0); end
        send_line(5'd5, WIDTH, 3, 1'b1);
        wait_drain(1000, ok);
        n_cmp++;
        if (!ok || n_beats - b0 != WIDTH) begin
            n_bad++; $display("FAIL length_followup_count: got %0d, want %0d", n_beats - b0, WIDTH);
        end
        n_cmp++;
        if (err_overrun !== 1'b0) begin n_bad++; $display("FAIL length_no_overrun: got %0b, want 0", err_overrun); end
    endtask

    task automatic test_overrun();
        int b0;
        bit ok;
        set_ready(1'b0);
        b0 = n_beats;
        send_line(5'd8,  WIDTH, 1, 1'b1);
        send_line(5'd9,  WIDTH, 2, 1'b1);
        send_line(5'd10, WIDTH, 4, 1'b0);
        repeat (10) @(negedge display_clock);
        n_cmp++;
        if (err_overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_flag: got %0b, want 1", err_overrun); end
        n_cmp++;
        if (n_beats != b0) begin n_bad++; $display("FAIL overrun_stalled_beats: got %0d, want 0", n_beats - b0); end
        set_ready(1'b1);
        wait_drain(1000, ok);
        repeat (50) @(negedge display_clock);
        n_cmp++;
        if (!ok || n_beats - b0 != 2 * WIDTH) begin
            n_bad++; $display("FAIL overrun_release_count: got %0d, want %0d", n_beats - b0, 2 * WIDTH);
        end
    endtask

    task automatic test_random_ready();
        int b0;
        int n;
        set_ready(1'b0);
        b0 = n_beats;
        send_line(5'd12, WIDTH, 9, 1'b1);
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(posedge display_clock);
            #1 cap_ready = 1'($urandom_range(0, 1));
            n++;
        end
        set_ready(1'b1);
        repeat (10) @(negedge display_clock);
        n_cmp++;
        if (sb.size() != 0 || n_beats - b0 != WIDTH) begin
            n_bad++; $display("FAIL random_ready_count: got %0d, want %0d", n_beats - b0, WIDTH);
        end
    endtask

    task automatic test_reset_mid();
        logic [24:0] outs;
        int  b0;
        int  n;
        bit  found;
        bit  ok;
        set_ready(1'b1);
        send_line(5'd2, WIDTH, 5, 1'b1);
        found = 1'b0;
        n = 0;
        while (!found && n < 1000) begin
            @(posedge display_clock);
            #1 found = cap_valid && (cap_col == 7'd40);
            n++;
        end
        n_cmp++;
        if (!found) begin n_bad++; $display("FAIL reset_mid_reach_col40: got col=%0d, want 40", cap_col); end
        display_reset_n = 1'b0;
        #1 outs = {cap_valid, cap_row, cap_col, cap_plane, cap_rgb, cap_frame, err_overrun, err_length};
        n_cmp++;
        if (outs !== '0) begin n_bad++; $display("FAIL reset_mid_outputs: got %h, want 0", outs); end
        sb.delete();
        m_last_row = '1;
        m_plane    = '0;
        repeat (3) @(posedge display_clock);
        #1 display_reset_n = 1'b1;
        b0 = n_beats;
        send_line(5'd0, WIDTH, 0, 1'b1);
        wait_drain(1000, ok);
        n_cmp++;
        if (!ok || n_beats - b0 != WIDTH) begin
            n_bad++; $display("FAIL reset_mid_fresh_count: got %0d, want %0d", n_beats - b0, WIDTH);
        end
        n_cmp++;
        if ({err_overrun, err_length} !== 2'b00) begin
            n_bad++; $display("FAIL reset_mid_errors: got ovr=%0b len=%0b, want 0 0", err_overrun, err_length);
        end
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_planes();
        test_length();
        test_overrun();
        test_random_ready();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
